// File: rtl/ucisc_pkg.sv
// rtl/ucisc_pkg.sv - shared states, selects and field positions for the uCISC sequencer
package ucisc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_FETCH    = 3'd0;
  localparam state_t ST_DECODE   = 3'd1;
  localparam state_t ST_LOAD_SRC = 3'd2;
  localparam state_t ST_LOAD_DST = 3'd3;
  localparam state_t ST_EXECUTE  = 3'd4;
  localparam state_t ST_WRITE    = 3'd5;

  localparam logic [3:0] OP_COPY = 4'h0;

  localparam logic [2:0] SEL_PC     = 3'd0;
  localparam logic [2:0] SEL_MEM_LO = 3'd1;
  localparam logic [2:0] SEL_MEM_HI = 3'd3;
  localparam logic [2:0] SEL_FLAGS  = 3'd4;
  localparam logic [2:0] SEL_IMM    = 3'd4;
  localparam logic [2:0] SEL_REG_LO = 3'd5;
  localparam logic [2:0] SEL_REG_HI = 3'd7;

  localparam int OPC_LSB = 12;
  localparam int DST_LSB = 9;
  localparam int SRC_LSB = 6;
  localparam int INC_BIT = 5;
  localparam int IMM_MSB = 4;

  function automatic logic sel_in(input logic [2:0] sel, input logic [2:0] lo, input logic [2:0] hi);
    return (sel >= lo) && (sel <= hi);
  endfunction

endpackage

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - combinational field split and operand classification
module instruction_decode
  import ucisc_pkg::*;
(
  input  logic [15:0] instr,
  output logic [3:0]  opcode,
  output logic [2:0]  dst,
  output logic [2:0]  src,
  output logic [6:0]  imm,
  output logic        is_src_mem,
  output logic        is_dst_mem,
  output logic        is_dst_store,
  output logic        needs_dst_load,
  output logic        is_push,
  output logic        is_pop
);

  logic inc;

  always_comb begin
    opcode         = instr[OPC_LSB +: 4];
    dst            = instr[DST_LSB +: 3];
    src            = instr[SRC_LSB +: 3];
    inc            = instr[INC_BIT];
    imm            = {{2{instr[IMM_MSB]}}, instr[IMM_MSB:0]};
    is_src_mem     = sel_in(src, SEL_MEM_LO, SEL_MEM_HI);
    is_dst_mem     = sel_in(dst, SEL_MEM_LO, SEL_MEM_HI);
    is_dst_store   = (dst == SEL_FLAGS) || sel_in(dst, SEL_REG_LO, SEL_REG_HI);
    // COPY overwrites the destination, so its old memory value is never needed
    needs_dst_load = is_dst_mem && (opcode != OP_COPY);
    is_push        = inc && is_dst_mem;
    is_pop         = inc && !is_dst_mem && is_src_mem;
  end

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - multi-cycle fetch/decode/operand/execute control for the uCISC core
module instruction_sequencer
  import ucisc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] pc,
  output logic [2:0]  source_select,
  output logic [2:0]  destination_select,
  output logic [6:0]  immediate,
  output logic        source_immediate,
  output logic [15:0] destination_write,
  output logic [15:0] flags_value,
  output logic        set_flags,
  output logic        store_value,
  output logic        pre_increment,
  output logic        post_increment,
  output logic        decrement,
  input  logic [15:0] source_out,
  input  logic [15:0] destination_out,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  input  logic [3:0]  alu_flags
);

  state_t      state;
  logic        started;
  logic [15:0] instr;
  logic [15:0] src_val;
  logic [15:0] dst_val;
  logic [15:0] result_q;
  logic        is_src_mem;
  logic        is_dst_mem;
  logic        is_dst_store;
  logic        needs_dst_load;
  logic        is_push;
  logic        is_pop;
  logic        mem_done;

  instruction_decode u_decode (
    .instr          (instr),
    .opcode         (alu_opcode),
    .dst            (destination_select),
    .src            (source_select),
    .imm            (immediate),
    .is_src_mem     (is_src_mem),
    .is_dst_mem     (is_dst_mem),
    .is_dst_store   (is_dst_store),
    .needs_dst_load (needs_dst_load),
    .is_push        (is_push),
    .is_pop         (is_pop)
  );

  assign source_immediate = (source_select == SEL_IMM);
  assign flags_value      = {12'h000, alu_flags};
  assign mem_done         = mem_ready && (mem_read || mem_write);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      started  <= 1'b0;
      instr    <= 16'h0000;
      src_val  <= 16'h0000;
      dst_val  <= 16'h0000;
      result_q <= 16'h0000;
    end else begin
      started <= 1'b1;
      case (state)
        ST_FETCH: begin
          if (mem_done) begin
            instr <= mem_rdata;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_src_mem)          state <= ST_LOAD_SRC;
          else if (needs_dst_load) state <= ST_LOAD_DST;
          else                     state <= ST_EXECUTE;
        end
        ST_LOAD_SRC: begin
          if (mem_done) begin
            src_val <= mem_rdata;
            state   <= needs_dst_load ? ST_LOAD_DST : ST_EXECUTE;
          end
        end
        ST_LOAD_DST: begin
          if (mem_done) begin
            dst_val <= mem_rdata;
            state   <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          result_q <= alu_result;
          if (is_dst_mem) begin
            state <= ST_WRITE;
          end else begin
            state <= ST_FETCH;
            pc    <= (destination_select == SEL_PC) ? alu_result : pc + 16'd1;
          end
        end
        ST_WRITE: begin
          if (mem_done) begin
            pc    <= pc + 16'd1;
            state <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  // The first cycle after reset release is idle so no strobe is ever raised while reset_n is low
  always_comb begin
    mem_addr          = 16'h0000;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_wdata         = 16'h0000;
    alu_a             = 16'h0000;
    alu_b             = 16'h0000;
    destination_write = 16'h0000;
    set_flags         = 1'b0;
    store_value       = 1'b0;
    pre_increment     = 1'b0;
    post_increment    = 1'b0;
    decrement         = 1'b0;
    case (state)
      ST_FETCH: begin
        if (started) begin
          mem_read = 1'b1;
          mem_addr = pc;
        end
      end
      ST_LOAD_SRC: begin
        mem_read = 1'b1;
        mem_addr = source_out;
      end
      ST_LOAD_DST: begin
        mem_read = 1'b1;
        mem_addr = destination_out;
      end
      ST_EXECUTE: begin
        alu_a             = is_dst_mem ? dst_val : destination_out;
        alu_b             = is_src_mem ? src_val : source_out;
        set_flags         = (alu_opcode != OP_COPY) && (destination_select != SEL_FLAGS);
        store_value       = is_dst_store;
        destination_write = is_dst_store ? alu_result : 16'h0000;
        post_increment    = is_pop;
      end
      ST_WRITE: begin
        mem_write      = 1'b1;
        mem_addr       = destination_out;
        mem_wdata      = result_q;
        post_increment = is_push && mem_ready;
      end
      default: ;
    endcase
    if (is_push && (state != ST_FETCH)) begin
      pre_increment = 1'b1;
      decrement     = 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - directed self-checking bench for instruction_sequencer
module tb_instruction_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ready = 1'b0;
  logic [15:0] pc;
  logic [2:0]  source_select;
  logic [2:0]  destination_select;
  logic [6:0]  immediate;
  logic        source_immediate;
  logic [15:0] destination_write;
  logic [15:0] flags_value;
  logic        set_flags;
  logic        store_value;
  logic        pre_increment;
  logic        post_increment;
  logic        decrement;
  logic [15:0] source_out;
  logic [15:0] destination_out;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic [3:0]  alu_flags;

  int checks = 0;
  int failures = 0;
  int wait_cfg = 0;
  int wait_cnt = 0;
  int write_count = 0;
  int n_store = 0;
  int n_setf = 0;
  int n_post = 0;
  int n_post_dec = 0;
  logic [15:0] last_waddr = 16'h0000;
  logic [15:0] last_wdata = 16'h0000;
  logic [15:0] mem [0:65535];
  logic [15:0] reg_r [0:3];
  logic [15:0] flags_reg = 16'h0000;
  logic [15:0] imm16;

  instruction_sequencer #(.RESET_PC(16'h0100)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .mem_addr           (mem_addr),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_wdata          (mem_wdata),
    .mem_rdata          (mem_rdata),
    .mem_ready          (mem_ready),
    .pc                 (pc),
    .source_select      (source_select),
    .destination_select (destination_select),
    .immediate          (immediate),
    .source_immediate   (source_immediate),
    .destination_write  (destination_write),
    .flags_value        (flags_value),
    .set_flags          (set_flags),
    .store_value        (store_value),
    .pre_increment      (pre_increment),
    .post_increment     (post_increment),
    .decrement          (decrement),
    .source_out         (source_out),
    .destination_out    (destination_out),
    .alu_opcode         (alu_opcode),
    .alu_a              (alu_a),
    .alu_b              (alu_b),
    .alu_result         (alu_result),
    .alu_flags          (alu_flags)
  );

  always #5 clock = ~clock;

  // Register block and ALU models: sel 0 = pc, 1-3/5-7 = r1-r3, 4 = immediate
  always_comb begin
    imm16 = {{9{immediate[6]}}, immediate};
    case (source_select)
      3'd0:    source_out = pc;
      3'd4:    source_out = imm16;
      default: source_out = reg_r[source_select[1:0]];
    endcase
    case (destination_select)
      3'd0:    destination_out = pc;
      3'd4:    destination_out = flags_reg;
      default: destination_out = reg_r[destination_select[1:0]] - {15'h0000, pre_increment & decrement};
    endcase
    case (alu_opcode)
      4'h0:    alu_result = alu_b;
      4'h1:    alu_result = alu_a + alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_flags = {3'b000, alu_result == 16'h0000};
  end

  // Memory with wait_cfg wait states, plus register-block commits on the clock edge
  always @(posedge clock) begin
    if (mem_ready && mem_write) begin
      mem[mem_addr] = mem_wdata;
      write_count++;
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
    end
    if (store_value) begin
      if (destination_select == 3'd4) flags_reg = destination_write;
      else reg_r[destination_select[1:0]] = destination_write;
    end
    if (set_flags) flags_reg = flags_value;
    if (post_increment) begin
      if (decrement) reg_r[destination_select[1:0]] = reg_r[destination_select[1:0]] - 16'd1;
      else reg_r[source_select[1:0]] = reg_r[source_select[1:0]] + 16'd1;
    end
    #1;
    if (!(mem_read || mem_write)) begin
      mem_ready = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= wait_cfg) begin
      mem_ready = 1'b1;
      mem_rdata = mem_read ? mem[mem_addr] : 16'h0000;
      wait_cnt = 0;
    end else begin
      mem_ready = 1'b0;
      wait_cnt++;
    end
  end

  always @(negedge clock) begin
    if (store_value) n_store++;
    if (set_flags) n_setf++;
    if (post_increment) begin
      n_post++;
      if (decrement) n_post_dec++;
    end
  end

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic wait_fetch(input logic [15:0] addr, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(mem_read && mem_addr == addr && pc == addr) && n < 200);
    check($sformatf("fetch_%h_addr", addr), mem_addr, addr);
    check($sformatf("fetch_%h_pc", addr), pc, addr);
  endtask

  task automatic wait_write(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!mem_write && n < 100);
    check(tag, {15'h0000, mem_write}, 16'h0001);
  endtask

  initial begin
    int wc, ns, nsf, np, npd, cyc;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 4; i++) reg_r[i] = 16'h0000;
    mem[16'h0100] = 16'h0B05;  // COPY imm 5 -> r1
    mem[16'h0101] = 16'h0D08;  // COPY imm 8 -> r2
    mem[16'h0102] = 16'h1440;  // ADD mem[r1] + mem[r2] -> mem[r2]
    mem[16'h0103] = 16'h0AA0;  // pop: r1 <- mem[r2], r2++
    mem[16'h0104] = 16'h0327;  // push imm 7 via r1
    mem[16'h0105] = 16'h011F;  // COPY imm -1 -> pc
    mem[16'hFFFF] = 16'h0100;  // COPY imm 0 -> pc
    mem[16'h0000] = 16'h0503;  // COPY imm 3 -> mem[r2]
    mem[16'h0005] = 16'h1234;
    mem[16'h0008] = 16'h0101;

    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_pc", pc, 16'h0100);
    check("rst_mem_read", {15'h0, mem_read}, 16'h0);
    check("rst_mem_write", {15'h0, mem_write}, 16'h0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_store_value", {15'h0, store_value}, 16'h0);
    check("rst_set_flags", {15'h0, set_flags}, 16'h0);
    check("rst_post_increment", {15'h0, post_increment}, 16'h0);
    check("rst_pre_increment", {15'h0, pre_increment}, 16'h0);
    check("rst_alu_a", alu_a, 16'h0000);
    check("rst_alu_b", alu_b, 16'h0000);
    check("rst_destination_write", destination_write, 16'h0000);

    reset_n = 1'b1;
    @(negedge clock);
    check("c1_mem_read", {15'h0, mem_read}, 16'h1);
    check("c1_mem_addr", mem_addr, 16'h0100);
    check("c1_store_value", {15'h0, store_value}, 16'h0);
    @(negedge clock);
    check("c2_store_value", {15'h0, store_value}, 16'h0);
    check("c2_destination_select", {13'h0, destination_select}, 16'h0005);
    check("c2_source_immediate", {15'h0, source_immediate}, 16'h1);
    check("c2_immediate", {9'h0, immediate}, 16'h0005);
    @(negedge clock);
    check("c3_store_value", {15'h0, store_value}, 16'h1);
    check("c3_destination_write", destination_write, 16'h0005);
    check("c3_set_flags", {15'h0, set_flags}, 16'h0);
    @(negedge clock);
    check("c4_next_fetch_read", {15'h0, mem_read}, 16'h1);
    check("c4_next_fetch_addr", mem_addr, 16'h0101);
    check("c4_store_value", {15'h0, store_value}, 16'h0);
    check("copy_r1", reg_r[1], 16'h0005);

    wait_cfg = 2;
    wait_fetch(16'h0102, cyc);
    check("copy_r2", reg_r[2], 16'h0008);
    wc = write_count;
    nsf = n_setf;
    wait_write("alu_write_seen");
    check("alu_write_addr_held", mem_addr, 16'h0008);
    wait_cfg = 0;
    wait_fetch(16'h0103, cyc);
    check("alu_write_count", 16'(write_count - wc), 16'h0001);
    check("alu_write_addr", last_waddr, 16'h0008);
    check("alu_write_data", last_wdata, 16'h1335);
    check("alu_set_flags_pulses", 16'(n_setf - nsf), 16'h0001);

    np = n_post;
    npd = n_post_dec;
    wait_fetch(16'h0104, cyc);
    check("pop_cycles", 16'(cyc), 16'h0004);
    check("pop_r1", reg_r[1], 16'h1335);
    check("pop_r2", reg_r[2], 16'h0009);
    check("pop_post_inc", 16'(n_post - np), 16'h0001);
    check("pop_post_dec", 16'(n_post_dec - npd), 16'h0000);

    reg_r[1] = 16'h0010;
    wc = write_count;
    np = n_post;
    npd = n_post_dec;
    ns = n_store;
    wait_fetch(16'h0105, cyc);
    check("push_write_count", 16'(write_count - wc), 16'h0001);
    check("push_write_addr", last_waddr, 16'h000F);
    check("push_write_data", last_wdata, 16'h0007);
    check("push_post_inc", 16'(n_post - np), 16'h0001);
    check("push_post_dec", 16'(n_post_dec - npd), 16'h0001);
    check("push_r1", reg_r[1], 16'h000F);
    check("push_store", 16'(n_store - ns), 16'h0000);

    ns = n_store;
    wait_fetch(16'hFFFF, cyc);
    wait_fetch(16'h0000, cyc);
    check("jump_store", 16'(n_store - ns), 16'h0000);

    wait_cfg = 3;
    wc = write_count;
    wait_write("rst_write_seen");
    check("rst_write_addr", mem_addr, 16'h0009);
    reset_n = 1'b0;
    #1;
    check("rst_mid_mem_write", {15'h0, mem_write}, 16'h0);
    check("rst_mid_mem_read", {15'h0, mem_read}, 16'h0);
    check("rst_mid_pc", pc, 16'h0100);
    repeat (3) @(negedge clock);
    check("rst_no_write", 16'(write_count - wc), 16'h0000);
    check("rst_mem9", mem[16'h0009], 16'h0000);
    reset_n = 1'b1;
    wait_cfg = 0;
    wait_fetch(16'h0100, cyc);
    check("rst_no_write_after", 16'(write_count - wc), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Multi-cycle control sequencer for the single-IPC uCISC core: fetches each 16-bit instruction, decodes it, performs memory operand reads and writes, and drives every control input of the register block. It is the producer of the select, immediate, increment and store strobes that the register block consumes, and the sole owner of the program counter.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem_addr  out  16  word address of current memory request
- mem_read / mem_write  out  1  request strobes, at most one high
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid when mem_ready
- mem_ready  in  1  request completes on the edge where ready and a strobe are both high
- pc  out  16  current PC
- source_select / destination_select  out  3  instruction fields [8:6] / [11:9]
- immediate  out  7  instruction [4:0] sign-extended
- source_immediate  out  1  high when source_select == 4
- destination_write  out  16  value for register/flags store
- flags_value  out  16  ALU flags, zero-extended
- set_flags, store_value, pre_increment, post_increment, decrement  out  1  register-block strobes
- source_out / destination_out  in  16  register-block operand/address values
- alu_opcode  out  4  instruction [15:12]
- alu_a / alu_b  out  16  destination operand / source operand
- alu_result  in  16, alu_flags  in  4  combinational ALU result

## Operation
- Instruction format: [15:12] opcode, [11:9] dst, [8:6] src, [5] inc, [4:0] imm. Opcode 0 = COPY.
- Source operand: src 1–3 → mem[source_out]; others → source_out directly.
- Destination: 0 = PC, 1–3 = mem[destination_out], 4 = flags, 5–7 = r1–r3.
- States: FETCH → DECODE → LOAD_SRC (src 1–3 only) → LOAD_DST (dst 1–3 and opcode ≠ COPY only) → EXECUTE → WRITE (dst 1–3 only) → FETCH.
- FETCH: mem_read, mem_addr = pc; instruction latched on completion.
- DECODE: one cycle; fields registered, outputs settle.
- EXECUTE: alu_result latched. Dst 4–7: store_value = 1, destination_write = alu_result; ends instruction. Dst 0: pc ← alu_result. Otherwise pc ← pc + 1 at instruction end.
- set_flags asserted in EXECUTE when opcode ≠ COPY and dst ≠ 4.
- WRITE: mem_write, mem_addr = destination_out, mem_wdata = latched result.
- Increment, inc = 1, dst 1–3 (push): pre_increment = decrement = 1 from DECODE through WRITE; post_increment = 1 on the final cycle only.
- Increment, inc = 1, dst not 1–3, src 1–3 (pop): post_increment = 1, decrement = 0 on the final cycle only.
- inc = 1 with no memory operand: ignored.
- All arithmetic is 16-bit modulo; pc + 1 wraps FFFF→0000.

## Timing
- Reset, asynchronous: state = FETCH, pc = RESET_PC; all strobes 0; mem_addr, mem_wdata, alu_a, alu_b, destination_write = 0.
- Memory requests hold address, data and strobe stable until mem_ready; unbounded wait states permitted.
- Minimum cycles with mem_ready tied high:
  - register-to-register: 3 (FETCH, DECODE, EXECUTE)
  - mem→reg COPY: 4
  - ALU op mem→mem: 6
- Reset mid-request drops the strobe immediately; no write completes after reset_n falls.
- store_value and post_increment are each high for exactly one cycle per instruction.

## Structure
- ucisc_pkg holds:
  - state enum
  - OP_COPY constant
  - select constants SEL_PC, SEL_FLAGS, and the memory/register select ranges
  - field-position localparams
- Sub-module instruction_decode, combinational, provides:
  - field split and immediate sign extension
  - is_src_mem, is_dst_mem, needs_dst_load, and push/pop classification

## Test plan
- Reset with RESET_PC = 16'h0100 → pc = 0100, first mem_read at 0100, all strobes low.
- COPY imm 5 → r1, instruction 16'h0B05 → store_value pulses in cycle 3, destination_select = 5, set_flags low, next fetch at pc + 1.
- ALU op mem[r1] + mem[r2] → mem[r2] with 2 wait states per access → exactly one mem_write to destination_out, pc + 1 afterwards.
- Push: inc = 1, dst = 1, r1 = 0010 → mem_write address 000F, single post_increment with decrement high.
- COPY to PC of value 0000 from pc FFFF → next fetch address 0000, no store_value.
- reset_n asserted while mem_write is pending → strobe drops the same cycle; after release, fetch resumes at RESET_PC.
